// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle stepped shifter (SLL/SRL/SRA/ROL) with start/done handshake
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROL = 2'd3;

  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic [SHW-1:0]   rem;
  logic [SHW-1:0]   k;
  logic [1:0]       op_q;
  logic             last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // One step is a chain of at most STEP single-bit shifts, each enabled while
  // its index is below k; this keeps the network STEP deep instead of a barrel.
  always_comb begin
    k         = (rem > STEP_AMT) ? STEP_AMT : rem;
    last_step = (rem == k);
    work_nxt  = work;
    for (int i = 0; i < STEP; i++) begin
      if (SHW'(i) < k) begin
        case (op_q)
          OP_SLL:  work_nxt = {work_nxt[WIDTH-2:0], 1'b0};
          OP_SRL:  work_nxt = {1'b0, work_nxt[WIDTH-1:1]};
          OP_SRA:  work_nxt = {work_nxt[WIDTH-1], work_nxt[WIDTH-1:1]};
          OP_ROL:  work_nxt = {work_nxt[WIDTH-2:0], work_nxt[WIDTH-1]};
          default: work_nxt = work_nxt;
        endcase
      end
    end
  end

  // out_data only moves on entry to DONE; a zero shift passes the operand through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      rem      <= '0;
      op_q     <= OP_SLL;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work <= in_data;
            rem  <= shamt;
            op_q <= op;
            if (shamt == '0) out_data <= in_data;
          end
        end
        S_SHIFT: begin
          work <= work_nxt;
          rem  <= rem - k;
          if (last_step) out_data <= work_nxt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - scoreboard bench for seq_shifter, 32-bit/STEP=4 and 16-bit/STEP=1 instances
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] in_data = 32'h0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] out32;
  logic [15:0] out16;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          last_e[2];
  int          n_of[2];
  int          free_at[2];
  logic [31:0] prev_res[2];
  logic [31:0] last_res[2];

  seq_shifter #(.WIDTH(32), .SHW(5), .STEP(4)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt),
    .in_data(in_data), .busy(busy0), .done(done0), .out_data(out32)
  );

  seq_shifter #(.WIDTH(16), .SHW(4), .STEP(1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt[3:0]),
    .in_data(in_data[15:0]), .busy(busy1), .done(done1), .out_data(out16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result from plain arithmetic over a w-bit operand.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [1:0] o,
                                            input int sh, input int w);
    logic [63:0] m, x;
    int r;
    m = (64'd1 << w) - 64'd1;
    x = {32'h0, a} & m;
    case (o)
      2'd0: return (sh >= w) ? 32'h0 : 32'((x << sh) & m);
      2'd1: return (sh >= w) ? 32'h0 : 32'(x >> sh);
      2'd2: begin
        if (x[w-1]) return (sh >= w) ? 32'(m) : 32'((x >> sh) | (m & ~(m >> sh)));
        else        return (sh >= w) ? 32'h0 : 32'(x >> sh);
      end
      default: begin
        r = sh % w;
        return 32'(((x << r) | (x >> (w - r))) & m);
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      last_e[d]   = -100;
      n_of[d]     = 0;
      free_at[d]  = 0;
      prev_res[d] = 32'h0;
      last_res[d] = 32'h0;
    end
  endtask

  // Decide, for the upcoming edge e, whether each instance accepts the request.
  task automatic model_edge(input int e);
    int w, st, sh, n;
    logic [31:0] a;
    exp_t x;
    if (!start) return;
    for (int d = 0; d < 2; d++) begin
      w  = (d == 0) ? 32 : 16;
      st = (d == 0) ? 4 : 1;
      sh = (d == 0) ? int'(shamt) : int'(shamt[3:0]);
      a  = (d == 0) ? in_data : {16'h0, in_data[15:0]};
      if (e >= free_at[d]) begin
        n           = (sh + st - 1) / st;
        x.res       = ref_shift(a, op, sh, w);
        x.cyc       = e + n;
        prev_res[d] = last_res[d];
        last_res[d] = x.res;
        last_e[d]   = e;
        n_of[d]     = n;
        free_at[d]  = e + n + 2;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
      end
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input int sh, input logic [31:0] a);
    start   = s;
    op      = o;
    shamt   = 5'(sh);
    in_data = a;
    model_edge(cyc + 1);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    while (cyc + 1 < free_at[0] || cyc + 1 < free_at[1]) drive(1'b0, 2'd0, 0, 32'h0);
  endtask

  task automatic mon(input int d, input logic b, input logic dn, input logic [31:0] o);
    int fin;
    exp_t x;
    fin = last_e[d] + n_of[d];
    chk($sformatf("busy%0d", d), {31'h0, b}, {31'h0, (cyc >= last_e[d] && cyc <= fin)});
    chk($sformatf("done%0d", d), {31'h0, dn}, {31'h0, (cyc == fin)});
    chk($sformatf("out%0d", d), o, (cyc >= fin) ? last_res[d] : prev_res[d]);
    if (dn) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL sb%0d: done with empty queue, got %h expected no result", d, o);
      end else begin
        x = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb_res%0d", d), o, x.res);
        chk($sformatf("sb_cyc%0d", d), 32'(cyc), 32'(x.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, busy0, done0, out32);
      mon(1, busy1, done1, {16'h0, out16});
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy0", {31'h0, busy0}, 32'h0);
    chk("rst_done0", {31'h0, done0}, 32'h0);
    chk("rst_out0", out32, 32'h0);
    chk("rst_busy1", {31'h0, busy1}, 32'h0);
    chk("rst_done1", {31'h0, done1}, 32'h0);
    chk("rst_out1", {16'h0, out16}, 32'h0);
  endtask

  // Launch a long SRA, pull reset in the middle of SHIFT, then release.
  task automatic reset_mid_op();
    drive(1'b1, 2'd2, 31, 32'h8000_8000);
    repeat (3) drive(1'b0, 2'd0, 0, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    drive(1'b1, 2'd0, 2, 32'h0000_0001);  idle();
    drive(1'b1, 2'd2, 31, 32'h8000_8000); idle();
    drive(1'b1, 2'd1, 31, 32'h8000_8000); idle();
    drive(1'b1, 2'd3, 8, 32'h1234_5678);  idle();
    drive(1'b1, 2'd1, 5, 32'hF000_F000);  idle();
    drive(1'b1, 2'd2, 0, 32'hDEAD_BEEF);  idle();

    drive(1'b1, 2'd2, 31, 32'h8000_8000);
    drive(1'b1, 2'd0, 3, 32'h1111_1111);
    drive(1'b1, 2'd3, 7, 32'h2222_2222);
    drive(1'b0, 2'd1, 9, 32'h3333_3333);
    idle();

    repeat (40) drive(1'b1, 2'd3, 13, 32'hA5C3_5A3C);
    idle();

    reset_mid_op();
    repeat (20) drive(1'b0, 2'd0, 0, 32'h0);

    for (int i = 0; i < 500; i++) begin
      if (i == 250) reset_mid_op();
      drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31)), $urandom);
    end
    idle();
    repeat (2) drive(1'b0, 2'd0, 0, 32'h0);

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle parametrised shifter for the datapath: logical left, logical right, arithmetic right and rotate left of a WIDTH-bit operand by a runtime amount. It shifts at most STEP bit positions per clock, so large shift amounts do not need a full barrel network. A start/done handshake lets the controller stall on it. The fixed branch-offset shift is this block with op=SLL and shamt=2.

## Interface
- WIDTH, 32: operand and result width in bits, must be at least 2.
- SHW, 5: width of the shift-amount port, with 2^SHW >= WIDTH.
- STEP, 4: maximum bit positions shifted per cycle, in the range 1..WIDTH-1.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only while busy=0.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- shamt  input  SHW  shift amount, unsigned.
- in_data  input  WIDTH  operand.
- busy  output  1  high while an operation is in progress, i.e. state is not IDLE.
- done  output  1  one-cycle pulse; result is valid while it is high.
- out_data  output  WIDTH  result register.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: applies one step per cycle.
  - DONE: holds the finished result for one cycle.
- IDLE with start=1 at a rising edge (the accepting edge):
  - Captures in_data into the working register, and captures op and shamt into the remaining-count register rem.
  - If shamt==0, goes to DONE; otherwise goes to SHIFT.
- IDLE with start=0: no change; out_data holds its last value.
- SHIFT, each edge:
  - Sets k = min(STEP, rem).
  - Shifts the working register by k per op:
    - SLL fills with zeros.
    - SRL fills with zeros.
    - SRA fills with the current MSB.
    - ROL moves bits shifted out of the MSB into the LSB.
  - Sets rem = rem - k.
  - If the new rem is 0, copies the result to out_data and goes to DONE.
- DONE: drives done=1 for one cycle, then goes to IDLE unconditionally.
- Shift amounts of WIDTH or more are legal and behave exactly as repeated single-bit shifts:
  - SLL and SRL give 0.
  - SRA gives all copies of the sign bit.
  - ROL rotates by shamt mod WIDTH.
- start while busy=1 is ignored. in_data, op and shamt may change freely after the accepting edge without affecting the operation.
- out_data changes only on the transition into DONE (or on reset). It holds that value until the next operation completes.
- Reset (rst_n=0 at any time, including mid-operation):
  - Immediately forces state=IDLE, busy=0, done=0, out_data=0, working register=0 and rem=0.
  - The aborted operation produces no done pulse.
- The first edge with rst_n=1 behaves as IDLE, so start may be accepted on that edge.

## Timing
- N = ceil(shamt / STEP).
- Accepting edge e:
  - busy=1 from after edge e until after edge e+N+1.
  - done=1 during exactly one cycle, the one following edge e+N. out_data is valid in the same cycle.
  - For shamt=0, done is high in the cycle right after edge e.
- Back-to-back throughput: the next start can be accepted at edge e+N+2, which is the first edge with state back in IDLE. A minimum of one idle edge separates operations.
- busy and done are registered outputs, with no combinational path from inputs.

## Test plan
- Reset, then SLL of 0x0000_0001 with shamt=2 (STEP=4): N=1; done is high in the cycle after edge e+1; out_data=0x0000_0004; busy falls after e+2.
- SRA of 0x8000_0000 with shamt=31: N=8; out_data=0xFFFF_FFFF; done is high for exactly one cycle after edge e+8. Then SRL of the same operand with shamt=31 gives 0x0000_0001.
- ROL of 0x1234_5678 with shamt=8 gives 0x3456_7812 after 2 steps. SRL of 0xF000_0000 with shamt=5 gives 0x0780_0000, exercising a partial final step of 4 then 1.
- shamt=0 with op=SRA on 0xDEAD_BEEF: done in the cycle after the accepting edge; out_data=0xDEAD_BEEF.
- start pulsed again mid-operation with different operands: ignored, and the original result is produced. Holding start high through DONE gives the next acceptance at edge e+N+2.
- Assert rst_n low during SHIFT of a shamt=31 operation: busy, done and out_data go to 0 immediately, and no done pulse follows. Repeat all of the above with WIDTH=16, SHW=4 and STEP=1.
